antilog_arbiter: RTL and testbench

//  Shares one antilog unit between N_CH sample sources (ch0 = pitch antenna, ch1 = volume antenna).

---
 rtl/theremin_pkg.sv | 12 +
 rtl/antilog_arbiter_rr_pick.sv | 23 ++
 rtl/antilog_arbiter.sv | 163 ++++++++++++++++
 tb/tb_antilog_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/theremin_pkg.sv
// Shared types and channel indices for the theremin sample path.
package theremin_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  localparam int CH_PITCH  = 0;
  localparam int CH_VOLUME = 1;

endpackage

// File: rtl/antilog_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending channel at or after ptr_i, wrapping.
module rr_pick #(
  parameter int N_CH = 2,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] pend_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic            any_o,
  output logic [CH_W-1:0] g_o
);

  always_comb begin
    g_o   = '0;
    any_o = |pend_i;
    // Walk offsets from far to near so the nearest pending channel is written last.
    for (int off = N_CH - 1; off >= 0; off--) begin
      if (pend_i[(int'(ptr_i) + off) % N_CH]) begin
        g_o = CH_W'((int'(ptr_i) + off) % N_CH);
      end
    end
  end

endmodule

// File: rtl/antilog_arbiter.sv
// Round-robin arbiter sharing one antilog unit between N_CH sample sources, with a per-transaction watchdog.
module antilog_arbiter
  import theremin_pkg::*;
#(
  parameter int IN_B    = 16,
  parameter int OUT_B   = 12,
  parameter int N_CH    = 2,
  parameter int TIMEOUT = 15,
  parameter int CNT_B   = 8,
  localparam int CH_W   = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH*IN_B-1:0]   ch_data,
  input  logic [N_CH-1:0]        ch_valid,
  output logic [IN_B-1:0]        al_in_data,
  output logic                   al_in_valid,
  input  logic [OUT_B-1:0]       al_out_data,
  input  logic                   al_out_valid,
  output logic [OUT_B-1:0]       res_data,
  output logic [CH_W-1:0]        res_ch,
  output logic                   res_valid,
  output logic                   res_timeout,
  output logic [N_CH*CNT_B-1:0]  ovf_cnt,
  output logic                   busy
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  arb_state_t                      state_q, state_d;
  logic [N_CH-1:0]                 pend_q, pend_d;
  logic [N_CH-1:0][IN_B-1:0]       buf_q, buf_d;
  logic [N_CH-1:0][CNT_B-1:0]      ovf_q, ovf_d;
  logic [CH_W-1:0]                 rr_q, rr_d;
  logic [CH_W-1:0]                 gnt_q, gnt_d;
  logic [WD_W-1:0]                 wdog_q, wdog_d;
  logic [IN_B-1:0]                 al_in_data_q, al_in_data_d;
  logic                            al_in_valid_q, al_in_valid_d;
  logic [OUT_B-1:0]                res_data_q, res_data_d;
  logic [CH_W-1:0]                 res_ch_q, res_ch_d;
  logic                            res_valid_q, res_valid_d;
  logic                            res_timeout_q, res_timeout_d;

  logic            pick_any;
  logic [CH_W-1:0] pick_g;
  logic            issue;
  logic            wdog_exp;

  function automatic logic [CNT_B-1:0] sat_inc(input logic [CNT_B-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  rr_pick #(.N_CH(N_CH), .CH_W(CH_W)) u_pick (
    .pend_i (pend_q),
    .ptr_i  (rr_q),
    .any_o  (pick_any),
    .g_o    (pick_g)
  );

  assign issue    = (state_q == IDLE) && pick_any;
  assign wdog_exp = (wdog_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = WAIT;
      WAIT:    if (al_out_valid || wdog_exp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pend_d        = pend_q;
    buf_d         = buf_q;
    ovf_d         = ovf_q;
    rr_d          = rr_q;
    gnt_d         = gnt_q;
    wdog_d        = wdog_q;
    al_in_data_d  = al_in_data_q;
    al_in_valid_d = 1'b0;
    res_data_d    = res_data_q;
    res_ch_d      = res_ch_q;
    res_valid_d   = 1'b0;
    res_timeout_d = 1'b0;

    if (issue) begin
      pend_d[pick_g] = 1'b0;
      al_in_data_d   = buf_q[pick_g];
      al_in_valid_d  = 1'b1;
      gnt_d          = pick_g;
      rr_d           = (int'(pick_g) == N_CH - 1) ? '0 : pick_g + 1'b1;
      wdog_d         = '0;
    end

    // A fresh strobe on the channel being granted re-arms it without counting as an overrun.
    for (int i = 0; i < N_CH; i++) begin
      if (ch_valid[i]) begin
        buf_d[i]  = ch_data[i*IN_B +: IN_B];
        pend_d[i] = 1'b1;
        if (pend_q[i] && !(issue && (pick_g == CH_W'(i)))) ovf_d[i] = sat_inc(ovf_q[i]);
      end
    end

    if (state_q == WAIT) begin
      wdog_d = wdog_q + 1'b1;
      if (al_out_valid) begin
        res_valid_d = 1'b1;
        res_data_d  = al_out_data;
        res_ch_d    = gnt_q;
      end else if (wdog_exp) begin
        res_valid_d   = 1'b1;
        res_timeout_d = 1'b1;
        res_data_d    = '0;
        res_ch_d      = gnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q        <= '0;
      buf_q         <= '0;
      ovf_q         <= '0;
      rr_q          <= '0;
      gnt_q         <= '0;
      wdog_q        <= '0;
      al_in_data_q  <= '0;
      al_in_valid_q <= 1'b0;
      res_data_q    <= '0;
      res_ch_q      <= '0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      buf_q         <= buf_d;
      ovf_q         <= ovf_d;
      rr_q          <= rr_d;
      gnt_q         <= gnt_d;
      wdog_q        <= wdog_d;
      al_in_data_q  <= al_in_data_d;
      al_in_valid_q <= al_in_valid_d;
      res_data_q    <= res_data_d;
      res_ch_q      <= res_ch_d;
      res_valid_q   <= res_valid_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign al_in_data  = al_in_data_q;
  assign al_in_valid = al_in_valid_q;
  assign res_data    = res_data_q;
  assign res_ch      = res_ch_q;
  assign res_valid   = res_valid_q;
  assign res_timeout = res_timeout_q;
  assign ovf_cnt     = ovf_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_antilog_arbiter.sv
// Directed bench for antilog_arbiter with a behavioural antilog stand-in and a result scoreboard.
module tb_antilog_arbiter;
  localparam int IN_B = 16, OUT_B = 12, N_CH = 2, TIMEOUT = 15, CNT_B = 8;
  localparam int IN_OFFSET = 3100;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N_CH*IN_B-1:0]  ch_data;
  logic [N_CH-1:0]       ch_valid;
  logic [IN_B-1:0]       al_in_data;
  logic                  al_in_valid;
  logic [OUT_B-1:0]      al_out_data;
  logic                  al_out_valid;
  logic [OUT_B-1:0]      res_data;
  logic [0:0]            res_ch;
  logic                  res_valid;
  logic                  res_timeout;
  logic [N_CH*CNT_B-1:0] ovf_cnt;
  logic                  busy;

  antilog_arbiter #(.IN_B(IN_B), .OUT_B(OUT_B), .N_CH(N_CH), .TIMEOUT(TIMEOUT), .CNT_B(CNT_B)) dut (
    .clk(clk), .reset(reset), .ch_data(ch_data), .ch_valid(ch_valid),
    .al_in_data(al_in_data), .al_in_valid(al_in_valid),
    .al_out_data(al_out_data), .al_out_valid(al_out_valid),
    .res_data(res_data), .res_ch(res_ch), .res_valid(res_valid), .res_timeout(res_timeout),
    .ovf_cnt(ovf_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Antilog stand-in: zero below the offset, saturating to full scale above it.
  int               lat = 2;
  logic             mute = 1'b0;
  logic             inj_vld = 1'b0;
  logic [OUT_B-1:0] inj_data = '0;
  logic             m_busy = 1'b0, m_vld = 1'b0;
  int               m_cnt = 0;
  logic [OUT_B-1:0] m_dat = '0, m_out = '0;

  function automatic logic [OUT_B-1:0] antilog_model(input logic [IN_B-1:0] x);
    int d;
    if (int'(x) < IN_OFFSET) return '0;
    d = (int'(x) - IN_OFFSET) * 4;
    return (d > 4095) ? 12'hFFF : OUT_B'(d);
  endfunction

  always_ff @(posedge clk) begin
    m_vld <= 1'b0;
    if (al_in_valid) begin
      m_busy <= 1'b1;
      m_cnt  <= lat - 1;
      m_dat  <= antilog_model(al_in_data);
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        m_vld  <= !mute;
        m_out  <= m_dat;
        m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign al_out_valid = m_vld | inj_vld;
  assign al_out_data  = inj_vld ? inj_data : m_out;

  typedef struct packed {
    logic [0:0]       ch;
    logic [OUT_B-1:0] data;
    logic             to;
  } exp_t;
  exp_t sb[$];

  int n_asrt = 0;
  int n_fail = 0;
  int last_lat = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1);
    ch_valid = v;
    ch_data  = {d1, d0};
    @(negedge clk);
    ch_valid = '0;
  endtask

  task automatic wait_result(input string tag, input int budget);
    exp_t e;
    int   n;
    bit   seen;
    seen = 0;
    n    = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (res_valid) seen = 1;
    end
    last_lat = n;
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (seen) begin
        chk({tag, "_ch"},   32'(res_ch),      32'(e.ch));
        chk({tag, "_data"}, 32'(res_data),    32'(e.data));
        chk({tag, "_to"},   32'(res_timeout), 32'(e.to));
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    ch_valid = '0;
    ch_data  = '0;
    idle_cycles(3);
    chk("rst_al_in_valid", 32'(al_in_valid), 32'd0);
    chk("rst_al_in_data",  32'(al_in_data),  32'd0);
    chk("rst_res_valid",   32'(res_valid),   32'd0);
    chk("rst_res_data",    32'(res_data),    32'd0);
    chk("rst_busy",        32'(busy),        32'd0);
    chk("rst_ovf",         32'(ovf_cnt),     32'd0);
    reset = 1'b0;
    idle_cycles(1);

    // 1: pitch sample below offset, issued on the edge after capture
    strobe(2'b01, 16'd3000, 16'd0);
    sb.push_back('{ch: 1'b0, data: 12'd0, to: 1'b0});
    @(negedge clk);
    chk("t1_issue_vld",  32'(al_in_valid), 32'd1);
    chk("t1_issue_data", 32'(al_in_data),  32'd3000);
    chk("t1_busy",       32'(busy),        32'd1);
    wait_result("t1", 20);
    idle_cycles(2);

    // 2: volume sample saturates to full scale
    strobe(2'b10, 16'd0, 16'd5000);
    sb.push_back('{ch: 1'b1, data: 12'hFFF, to: 1'b0});
    wait_result("t2", 20);
    idle_cycles(2);

    // 3: simultaneous requests after reset, twice
    reset = 1'b1;
    idle_cycles(1);
    reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      strobe(2'b11, 16'd3000, 16'd5000);
      sb.push_back('{ch: 1'b0, data: 12'd0,   to: 1'b0});
      sb.push_back('{ch: 1'b1, data: 12'hFFF, to: 1'b0});
      wait_result("t3_first", 20);
      wait_result("t3_second", 20);
      idle_cycles(2);
    end

    // 4: three pitch strobes while the volume transaction is outstanding
    lat = 5;
    strobe(2'b10, 16'd0, 16'd5000);
    @(negedge clk);
    chk("t4_busy", 32'(busy), 32'd1);
    strobe(2'b01, 16'd3000, 16'd0);
    strobe(2'b01, 16'd3050, 16'd0);
    strobe(2'b01, 16'd5000, 16'd0);
    sb.push_back('{ch: 1'b1, data: 12'hFFF, to: 1'b0});
    sb.push_back('{ch: 1'b0, data: 12'hFFF, to: 1'b0});
    wait_result("t4_ch1", 20);
    wait_result("t4_ch0", 20);
    chk("t4_ovf0", 32'(ovf_cnt[7:0]),  32'd2);
    chk("t4_ovf1", 32'(ovf_cnt[15:8]), 32'd0);
    idle_cycles(3);
    chk("t4_no_extra", 32'(sb.size()), 32'd0);

    // 5: unit never answers, watchdog closes the transaction
    lat  = 2;
    mute = 1'b1;
    strobe(2'b01, 16'd3000, 16'd0);
    @(negedge clk);
    chk("t5_issue_vld", 32'(al_in_valid), 32'd1);
    sb.push_back('{ch: 1'b0, data: 12'd0, to: 1'b1});
    wait_result("t5", TIMEOUT + 10);
    chk("t5_latency_ok", 32'((last_lat == TIMEOUT) || (last_lat == TIMEOUT + 1)), 32'd1);
    chk("t5_busy_drop", 32'(busy), 32'd0);
    idle_cycles(2);

    // 6: reset while waiting, then a late answer that must be ignored
    strobe(2'b10, 16'd0, 16'd5000);
    @(negedge clk);
    chk("t6_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    inj_data = 12'hABC;
    inj_vld  = 1'b1;
    @(negedge clk);
    inj_vld  = 1'b0;
    begin
      bit any_res;
      any_res = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (res_valid) any_res = 1;
      end
      chk("t6_no_res", 32'(any_res), 32'd0);
    end
    chk("t6_res_data",  32'(res_data),    32'd0);
    chk("t6_res_ch",    32'(res_ch),      32'd0);
    chk("t6_res_to",    32'(res_timeout), 32'd0);
    chk("t6_al_in",     32'(al_in_data),  32'd0);
    chk("t6_ovf",       32'(ovf_cnt),     32'd0);
    chk("t6_busy_idle", 32'(busy),        32'd0);
    mute = 1'b0;
    lat  = 3;
    strobe(2'b01, 16'd5000, 16'd0);
    sb.push_back('{ch: 1'b0, data: 12'hFFF, to: 1'b0});
    wait_result("t6_after", 20);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
